// File: rtl/mem_dump_ctrl_if.sv
// rtl/mem_dump_ctrl_if.sv - dump word stream between mem_dump_ctrl and its consumer
interface mem_dump_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  modport master (output out_valid, out_data, out_addr, input out_ready);
  modport slave  (input out_valid, out_data, out_addr, output out_ready);
endinterface

// File: rtl/mem_dump_ctrl.sv
// rtl/mem_dump_ctrl.sv - post-run memory dump controller
// Freezes the CPU data-memory port and streams words FIRST_ADDR..LAST_ADDR.
module mem_dump_ctrl #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 1,
  parameter int FIRST_ADDR = 0,
  parameter int LAST_ADDR  = 127
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  if_end,
  output logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data,
  mem_dump_ctrl_if.master       stream
);
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_HOLD, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               handshake;
  logic               at_last;

  assign handshake = (state == S_HOLD) && stream.out_ready;
  assign at_last   = (address == ADDR_W'(LAST_ADDR));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !abort) state_nxt = S_READ;
      S_READ: begin
        if (abort)            state_nxt = S_IDLE;
        else if (cnt == '0)   state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (abort)            state_nxt = S_IDLE;
        else if (handshake)   state_nxt = at_last ? S_DONE : S_READ;
      end
      S_DONE:                 state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy             = (state != S_IDLE);
    if_end           = (state != S_IDLE);
    done             = (state == S_DONE);
    stream.out_valid = (state == S_HOLD);
  end

  // Address stays put in IDLE/DONE so the last dumped address remains visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      address         <= '0;
      cnt             <= '0;
      stream.out_data <= '0;
      stream.out_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            address <= ADDR_W'(FIRST_ADDR);
            cnt     <= CNT_W'(READ_LAT - 1);
          end
        end
        S_READ: begin
          if (!abort) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              stream.out_data <= data;
              stream.out_addr <= address;
            end
          end
        end
        S_HOLD: begin
          if (handshake && !abort && !at_last) begin
            address <= address + 1'b1;
            cnt     <= CNT_W'(READ_LAT - 1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb/tb_mem_dump_ctrl.sv - scoreboard bench for mem_dump_ctrl
module tb_mem_dump_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [6:0] a);
    return 32'hA500_0000 + {25'd0, a};
  endfunction

  // Instance A: READ_LAT=1, window 0..127
  logic rst_a = 1, start_a = 0, abort_a = 0;
  logic busy_a, done_a, if_end_a;
  logic [6:0] address_a;
  logic [31:0] data_a;
  mem_dump_ctrl_if #(.ADDR_W(7), .DATA_W(32)) sa ();
  assign data_a = word(address_a);
  mem_dump_ctrl #(.READ_LAT(1), .FIRST_ADDR(0), .LAST_ADDR(127)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .abort(abort_a), .busy(busy_a),
    .done(done_a), .if_end(if_end_a), .address(address_a), .data(data_a), .stream(sa));

  // Instance B: READ_LAT=3, window 10..13, memory with matching latency
  logic rst_b = 1, start_b = 0, abort_b = 0;
  logic busy_b, done_b, if_end_b;
  logic [6:0] address_b, pb1, pb2;
  logic [31:0] data_b;
  mem_dump_ctrl_if #(.ADDR_W(7), .DATA_W(32)) sb ();
  always @(posedge clk) begin
    pb1 <= address_b;
    pb2 <= pb1;
  end
  assign data_b = word(pb2);
  mem_dump_ctrl #(.READ_LAT(3), .FIRST_ADDR(10), .LAST_ADDR(13)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b), .busy(busy_b),
    .done(done_b), .if_end(if_end_b), .address(address_b), .data(data_b), .stream(sb));

  // Instance C: READ_LAT=1, single-word window at 127
  logic rst_c = 1, start_c = 0, abort_c = 0;
  logic busy_c, done_c, if_end_c;
  logic [6:0] address_c;
  logic [31:0] data_c;
  mem_dump_ctrl_if #(.ADDR_W(7), .DATA_W(32)) sc ();
  assign data_c = word(address_c);
  mem_dump_ctrl #(.READ_LAT(1), .FIRST_ADDR(127), .LAST_ADDR(127)) dut_c (
    .clk(clk), .rst(rst_c), .start(start_c), .abort(abort_c), .busy(busy_c),
    .done(done_c), .if_end(if_end_c), .address(address_c), .data(data_c), .stream(sc));

  logic [6:0] qa[$], qb[$], qc[$];
  int dones_a = 0, dones_b = 0, dones_c = 0;

  initial begin
    sa.out_ready = 1'b0;
    sb.out_ready = 1'b0;
    sc.out_ready = 1'b0;
  end

  always @(negedge clk) begin
    if (done_a) dones_a++;
    if (sa.out_valid && sa.out_ready) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_extra_word actual addr=%0d required none", sa.out_addr);
      end else begin
        chk("a_addr", sa.out_addr, qa[0]);
        chk("a_data", sa.out_data, word(qa[0]));
        void'(qa.pop_front());
      end
    end
  end

  logic stall_b = 1'b0;
  logic [6:0] hold_addr_b;
  logic [31:0] hold_data_b;
  always @(negedge clk) begin
    if (done_b) dones_b++;
    if (stall_b) begin
      chk("b_stall_valid", sb.out_valid, 1);
      chk("b_stall_addr", sb.out_addr, hold_addr_b);
      chk("b_stall_data", sb.out_data, hold_data_b);
    end
    stall_b     <= sb.out_valid && !sb.out_ready;
    hold_addr_b <= sb.out_addr;
    hold_data_b <= sb.out_data;
    if (sb.out_valid && sb.out_ready) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_extra_word actual addr=%0d required none", sb.out_addr);
      end else begin
        chk("b_addr", sb.out_addr, qb[0]);
        chk("b_data", sb.out_data, word(qb[0]));
        void'(qb.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (done_c) dones_c++;
    if (sc.out_valid && sc.out_ready) begin
      if (qc.size() == 0) begin
        checks++; failures++;
        $display("FAIL c_extra_word actual addr=%0d required none", sc.out_addr);
      end else begin
        chk("c_addr", sc.out_addr, qc[0]);
        chk("c_data", sc.out_data, word(qc[0]));
        void'(qc.pop_front());
      end
    end
  end

  logic rand_b = 1'b0;
  always begin
    @(posedge clk);
    #2;
    if (rand_b) sb.out_ready = ($urandom_range(0, 1) == 1);
  end

  initial begin
    int dk, verr, d0;
    repeat (2) @(posedge clk);
    #1 rst_a = 0; rst_b = 0; rst_c = 0;
    @(negedge clk);
    chk("reset_busy", busy_a, 0);
    chk("reset_if_end", if_end_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_valid", sa.out_valid, 0);
    chk("reset_address", address_a, 0);
    chk("reset_out_addr", sa.out_addr, 0);
    chk("reset_out_data", sa.out_data, 0);

    // start and abort together in IDLE
    @(posedge clk); #1 start_a = 1; abort_a = 1;
    @(posedge clk); #1 start_a = 0; abort_a = 0;
    @(negedge clk);
    chk("start_abort_if_end", if_end_a, 0);
    chk("start_abort_busy", busy_a, 0);

    // full dump, out_ready high, start re-pulsed while busy
    sa.out_ready = 1;
    for (int i = 0; i < 128; i++) qa.push_back(7'(i));
    d0 = dones_a; dk = 0; verr = 0;
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int k = 1; k <= 262; k++) begin
      @(negedge clk);
      if (done_a && dk == 0) dk = k;
      if (k <= 256 && sa.out_valid !== ((k % 2) == 0)) verr++;
      if (k == 1) chk("first_read_address", address_a, 0);
      if (k == 1) chk("first_read_if_end", if_end_a, 1);
      if (k == 50) start_a = 1;
      if (k == 51) start_a = 0;
    end
    chk("full_done_cycle", dk, 257);
    chk("full_valid_pattern", verr, 0);
    chk("full_all_words", qa.size(), 0);
    chk("full_done_count", dones_a - d0, 1);

    // abort in HOLD at word 5 with handshake
    for (int i = 0; i < 6; i++) qa.push_back(7'(i));
    d0 = dones_a;
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int i = 0; i < 100 && !(sa.out_valid && sa.out_addr == 5); i++) @(negedge clk);
    chk("abort_reach_word5", sa.out_valid && sa.out_addr == 5, 1);
    abort_a = 1;
    @(posedge clk); #1 abort_a = 0;
    @(negedge clk);
    chk("abort_if_end", if_end_a, 0);
    chk("abort_busy", busy_a, 0);
    repeat (10) @(negedge clk);
    chk("abort_words", qa.size(), 0);
    chk("abort_no_done", dones_a - d0, 0);
    chk("abort_no_valid", sa.out_valid, 0);

    // reset in READ mid-dump, then a fresh dump
    for (int i = 0; i < 3; i++) qa.push_back(7'(i));
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int i = 0; i < 100 && !(busy_a && !sa.out_valid && address_a == 3); i++) @(negedge clk);
    chk("rst_reach_read3", busy_a && !sa.out_valid && address_a == 3, 1);
    rst_a = 1;
    @(posedge clk); #1 rst_a = 0;
    @(negedge clk);
    chk("rst_if_end", if_end_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", sa.out_valid, 0);
    chk("rst_address", address_a, 0);
    chk("rst_out_addr", sa.out_addr, 0);
    chk("rst_out_data", sa.out_data, 0);
    chk("rst_words", qa.size(), 0);
    for (int i = 0; i < 128; i++) qa.push_back(7'(i));
    d0 = dones_a;
    @(posedge clk); #1 start_a = 1;
    @(posedge clk); #1 start_a = 0;
    for (int i = 0; i < 400 && !done_a; i++) @(negedge clk);
    chk("redump_done", done_a, 1);
    @(negedge clk);
    chk("redump_words", qa.size(), 0);
    chk("redump_done_count", dones_a - d0, 1);

    // backpressure with READ_LAT=3, window 10..13
    for (int i = 10; i <= 13; i++) qb.push_back(7'(i));
    rand_b = 1;
    @(posedge clk); #1 start_b = 1;
    @(posedge clk); #1 start_b = 0;
    for (int i = 0; i < 300 && !done_b; i++) @(negedge clk);
    chk("b_done", done_b, 1);
    @(negedge clk);
    rand_b = 0;
    chk("b_words", qb.size(), 0);
    chk("b_done_count", dones_b, 1);

    // single-word window at 127
    sc.out_ready = 1;
    qc.push_back(7'd127);
    @(posedge clk); #1 start_c = 1;
    @(posedge clk); #1 start_c = 0;
    for (int i = 0; i < 20 && !done_c; i++) @(negedge clk);
    chk("c_done", done_c, 1);
    chk("c_done_address", address_c, 127);
    repeat (5) @(negedge clk);
    chk("c_words", qc.size(), 0);
    chk("c_done_count", dones_c, 1);
    chk("c_no_wrap", address_c, 127);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
